spi_tx_arbiter: RTL and testbench



---
 rtl/spi_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_spi_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI transmit master between NREQ requesters.
// Grants one requester, presents its latched word on newd/din, follows the frame via cs, then pulses done.
module spi_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int DW            = 12,
    parameter int ACK_TIMEOUT   = 64,
    parameter int FRAME_TIMEOUT = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               spi_newd,
    output logic [DW-1:0]      spi_din,
    input  logic               spi_cs,
    output logic               busy,
    output logic               err_timeout,
    output logic [1:0]         dbg_state
);

    localparam int RRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMAX = (ACK_TIMEOUT > FRAME_TIMEOUT) ? ACK_TIMEOUT : FRAME_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_IN_FRAME = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t            r_state;
    logic [RRW-1:0]    r_rr;
    logic [TW-1:0]     r_timer;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic              r_newd;
    logic [DW-1:0]     r_din;
    logic              r_err;
    logic              r_cs_meta;
    logic              r_cs_s;

    logic              w_any;
    logic [RRW-1:0]    w_win;
    logic [NREQ-1:0]   w_win_oh;
    logic [DW-1:0]     w_win_data;

    // First set request searching upward from the last winner + 1, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_any && req[(int'(r_rr) + k) % NREQ]) begin
                w_any = 1'b1;
                w_win = RRW'((int'(r_rr) + k) % NREQ);
            end
        end
    end

    assign w_win_oh   = NREQ'(1) << w_win;
    assign w_win_data = req_data[int'(w_win)*DW +: DW];

    // Handshake: newd acts as valid and the master's falling cs (after sync) as ready;
    // newd drops once cs_s is low, so the master never sees a second request for the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr      <= RRW'(NREQ - 1);
            r_timer   <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_newd    <= 1'b0;
            r_din     <= '0;
            r_err     <= 1'b0;
            r_cs_meta <= 1'b1;
            r_cs_s    <= 1'b1;
        end else begin
            r_cs_meta <= spi_cs;
            r_cs_s    <= r_cs_meta;
            r_done    <= '0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_cs_s && w_any) begin
                        r_gnt   <= w_win_oh;
                        r_din   <= w_win_data;
                        r_newd  <= 1'b1;
                        r_rr    <= w_win;
                        r_timer <= '0;
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    r_timer <= r_timer + 1'b1;
                    if (!r_cs_s) begin
                        r_newd  <= 1'b0;
                        r_timer <= '0;
                        r_state <= S_IN_FRAME;
                    end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                        r_newd  <= 1'b0;
                        r_gnt   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_IN_FRAME: begin
                    r_timer <= r_timer + 1'b1;
                    if (r_cs_s) begin
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_state <= S_DONE;
                    end else if (r_timer == TW'(FRAME_TIMEOUT - 1)) begin
                        r_gnt   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign spi_newd    = r_newd;
    assign spi_din     = r_din;
    assign busy        = (r_state != S_IDLE);
    assign err_timeout = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter with a small behavioural SPI master model driving cs.
// Table of arbitration vectors plus hand sequences for latency, timeouts and mid-frame reset.
module tb_spi_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 12;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               spi_newd;
    logic [DW-1:0]      spi_din;
    logic               spi_cs = 1'b1;
    logic               busy;
    logic               err_timeout;
    logic [1:0]         dbg_state;

    logic [DW-1:0] words [NREQ];
    assign req_data = {words[3], words[2], words[1], words[0]};

    int n_checks = 0;
    int n_errors = 0;

    spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .ACK_TIMEOUT(64), .FRAME_TIMEOUT(512)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .spi_newd    (spi_newd),
        .spi_din     (spi_din),
        .spi_cs      (spi_cs),
        .busy        (busy),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SPI master model ----------------
    // cs_mode 0: normal frames of 2*DW clocks; 1: never accepts (cs stays high);
    // 2: accepts and then holds cs low until cs_mode returns to 0.
    logic [1:0]    cs_mode  = 2'd0;
    logic [1:0]    m_state  = 2'd0;
    int            m_cnt    = 0;
    int            m_frames = 0;
    logic [DW-1:0] m_word   = '0;

    always @(posedge clk) begin
        case (m_state)
            2'd0: begin
                spi_cs <= 1'b1;
                if (spi_newd && cs_mode != 2'd1) begin
                    spi_cs   <= 1'b0;
                    m_word   <= spi_din;
                    m_frames <= m_frames + 1;
                    m_cnt    <= 0;
                    m_state  <= (cs_mode == 2'd2) ? 2'd3 : 2'd1;
                end
            end
            2'd1: begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 2*DW - 1) begin
                    spi_cs  <= 1'b1;
                    m_cnt   <= 0;
                    m_state <= 2'd2;
                end
            end
            2'd2: begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 1) m_state <= 2'd0;
            end
            default: begin
                if (cs_mode == 2'd0) begin
                    spi_cs  <= 1'b1;
                    m_cnt   <= 0;
                    m_state <= 2'd2;
                end
            end
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    // Invariants sampled every cycle: gnt one-hot-or-zero, done only for a bit granted last cycle.
    logic [NREQ-1:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!$onehot0(gnt)) chk("gnt_onehot", 32'(gnt), 32'(0));
            if (done != '0) chk("done_after_gnt", 32'(done & ~prev_gnt), 32'(0));
        end
        prev_gnt = gnt;
    end

    // ---------------- arbitration vectors ----------------
    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] exp_gnt;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cnt;
        int idx;
        int frames0;
        bit seen;
        bit done_seen;

        words[0] = 12'h001; words[1] = 12'h002; words[2] = 12'h003; words[3] = 12'h004;

        vecs[0]  = '{4'b1111, 4'b0001};
        vecs[1]  = '{4'b1111, 4'b0010};
        vecs[2]  = '{4'b1111, 4'b0100};
        vecs[3]  = '{4'b1111, 4'b1000};
        vecs[4]  = '{4'b1111, 4'b0001};
        vecs[5]  = '{4'b0010, 4'b0010};
        vecs[6]  = '{4'b0011, 4'b0001};
        vecs[7]  = '{4'b0011, 4'b0010};
        vecs[8]  = '{4'b1000, 4'b1000};
        vecs[9]  = '{4'b1001, 4'b0001};
        vecs[10] = '{4'b0110, 4'b0010};
        vecs[11] = '{4'b0110, 4'b0100};
        vecs[12] = '{4'b1100, 4'b1000};

        // ---- reset values ----
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_newd", 32'(spi_newd), 32'(0));
        chk("rst_din", 32'(spi_din), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err_timeout), 32'(0));
        rst = 1'b0;
        tick();

        // ---- single transfer of A5C from requester 0 ----
        words[0] = 12'hA5C;
        req = 4'b0001;
        tick();
        chk("a5c_gnt_latency", 32'(gnt), 32'(4'b0001));
        chk("a5c_newd_latency", 32'(spi_newd), 32'(1));
        chk("a5c_din", 32'(spi_din), 32'(12'hA5C));
        req = '0;
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (spi_cs == 1'b0 && spi_newd) cnt++;
            if (done != '0) seen = 1'b1;
            else tick();
        end
        chk("a5c_done_seen", 32'(seen), 32'(1));
        chk("a5c_done_bit", 32'(done), 32'(4'b0001));
        chk("a5c_newd_after_cs", 32'((cnt >= 2) && (cnt <= 3)), 32'(1));
        chk("a5c_master_word", 32'(m_word), 32'(12'hA5C));
        tick();
        chk("a5c_done_single", 32'(done), 32'(0));
        chk("a5c_busy_after", 32'(busy), 32'(0));
        words[0] = 12'h001;

        // ---- table: rotation order ----
        do_reset();
        frames0 = m_frames;
        for (int v = 0; v < NVEC; v++) begin
            req = vecs[v].req;
            idx = 0;
            for (int b = 0; b < NREQ; b++) if (vecs[v].exp_gnt[b]) idx = b;
            seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                tick();
                if (gnt != '0) seen = 1'b1;
            end
            chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].exp_gnt));
            chk($sformatf("vec%0d_din", v), 32'(spi_din), 32'(words[idx]));
            seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                tick();
                if (done != '0) seen = 1'b1;
            end
            chk($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_gnt));
            chk($sformatf("vec%0d_word", v), 32'(m_word), 32'(words[idx]));
        end
        req = '0;
        repeat (4) tick();
        chk("table_frame_count", 32'(m_frames - frames0), 32'(NVEC));

        // ---- ACK timeout: master never lowers cs ----
        do_reset();
        cs_mode = 2'd1;
        req = 4'b0100;
        tick();
        req = '0;
        chk("ack_to_gnt", 32'(gnt), 32'(4'b0100));
        cnt = 0;
        for (int i = 0; i < 200 && spi_newd; i++) begin
            cnt++;
            tick();
        end
        chk("ack_to_newd_cycles", 32'(cnt), 32'(64));
        chk("ack_to_err", 32'(err_timeout), 32'(1));
        chk("ack_to_gnt_clr", 32'(gnt), 32'(0));
        chk("ack_to_no_done", 32'(done), 32'(0));
        tick();
        chk("ack_to_err_pulse", 32'(err_timeout), 32'(0));
        chk("ack_to_idle", 32'(busy), 32'(0));
        cs_mode = 2'd0;
        repeat (4) tick();

        // ---- frame timeout: cs held low after acceptance ----
        do_reset();
        cs_mode = 2'd2;
        req = 4'b0001;
        tick();
        req = '0;
        for (int i = 0; i < 50 && spi_newd; i++) tick();
        chk("frm_to_in_frame", 32'(spi_newd), 32'(0));
        cnt = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 2000 && !err_timeout; i++) begin
            tick();
            cnt++;
            if (done != '0) done_seen = 1'b1;
        end
        chk("frm_to_cycles", 32'(cnt), 32'(512));
        chk("frm_to_err", 32'(err_timeout), 32'(1));
        chk("frm_to_gnt_clr", 32'(gnt), 32'(0));
        chk("frm_to_no_done", 32'(done_seen | (done != '0)), 32'(0));
        cs_mode = 2'd0;
        repeat (6) tick();
        chk("frm_to_idle", 32'(busy), 32'(0));

        // ---- reset in the middle of a frame ----
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        for (int i = 0; i < 50 && spi_newd; i++) tick();
        repeat (4) tick();
        chk("mid_rst_cs_low", 32'(spi_cs), 32'(0));
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt", 32'(gnt), 32'(0));
        chk("mid_rst_newd", 32'(spi_newd), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_din", 32'(spi_din), 32'(0));
        tick();
        rst = 1'b0;
        repeat (3) tick();
        req = 4'b0010;
        cnt = 0;
        seen = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            cnt = spi_cs ? cnt + 1 : 0;
            if (done != '0) done_seen = 1'b1;
            if (gnt != '0) seen = 1'b1;
        end
        chk("mid_rst_no_done", 32'(done_seen), 32'(0));
        chk("mid_rst_regrant", 32'(gnt), 32'(4'b0010));
        chk("mid_rst_cs_sync_wait", 32'(cnt), 32'(4));
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (done != '0) seen = 1'b1;
        end
        chk("mid_rst_done", 32'(done), 32'(4'b0010));
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
